// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       loaded_words;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, loaded_words
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, loaded_words
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes big-endian words into
// instruction memory at 0, 4, 8, ... and holds the CPU in reset until loading finishes.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 512,
  parameter int unsigned ADDR_W    = 9
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sh;
  logic [15:0]       loaded_words;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  logic              xfer;
  logic [15:0]       n_full;
  logic [15:0]       words_inc;

  // Next-state decode; in_ready is a registered flag so no input reaches an output.
  always_comb begin
    state_nx  = state;
    xfer      = bus.in_valid & in_ready;
    n_full    = {len[15:8], bus.in_data};
    words_inc = loaded_words + 16'd1;
    case (state)
      S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (n_full == 16'd0)                 state_nx = S_DONE;
          else if (n_full > 16'(MAX_WORDS))    state_nx = S_ERR;
          else                                 state_nx = S_DATA;
        end
      end
      S_DATA:   if (xfer && byte_cnt == 2'd3) state_nx = S_WRITE;
      S_WRITE:  state_nx = (words_inc == len) ? S_DONE : S_DATA;
      default:  state_nx = state;
    endcase
  end

  // State, datapath and status flags; flags are decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_LEN_HI;
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      word_sh      <= 24'd0;
      loaded_words <= 16'd0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) || (state_nx == S_DATA);
      mem_we   <= (state_nx == S_WRITE);
      cpu_hold <= (state_nx != S_DONE);
      done     <= (state_nx == S_DONE);
      error    <= (state_nx == S_ERR);
      if (xfer) begin
        case (state)
          S_LEN_HI: len[15:8] <= bus.in_data;
          S_LEN_LO: len[7:0]  <= bus.in_data;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sh  <= {word_sh[15:0], bus.in_data};
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {word_sh, bus.in_data};
              mem_addr  <= ADDR_W'({loaded_words, 2'b00});
            end
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) loaded_words <= words_inc;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.cpu_hold     = cpu_hold;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.loaded_words = loaded_words;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle MIPS CPU's instruction memory: the CPU only reads that memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory at consecutive byte addresses 0, 4, 8, …
- Holds the CPU in reset until the whole program is loaded.

Parameters:
MEM_BYTES, 512, instruction memory size in bytes; max loadable words = MEM_BYTES/4.
ADDR_W, 9, width of mem_addr (byte address); must satisfy 2^ADDR_W >= MEM_BYTES.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge).
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  stream byte.
in_ready  output  1  loader can accept a byte this cycle.
mem_we  output  1  instruction memory write enable, one cycle per word.
mem_addr  output  ADDR_W  byte address of word being written (always multiple of 4).
mem_wdata  output  32  word being written.
cpu_hold  output  1  1 = keep CPU in reset; drives CPU reset.
done  output  1  program fully loaded (sticky).
error  output  1  length exceeds capacity (sticky).
loaded_words  output  16  count of words written so far.

Behaviour:
- Transfer occurs on a rising edge with in_valid=1 and in_ready=1. The source must hold in_data stable while in_valid=1 and in_ready=0.
- Stream format: 2-byte word count N (high byte first), then 4*N data bytes. Each word is big-endian: the first byte goes to bits 31:24.
- States: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- Reset (reset=0 at an edge) produces:
  - state LEN_HI
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1, done=0, error=0, loaded_words=0
  - internal byte counter=0, N=0
- LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
- LEN_LO: on transfer, latch N[7:0]. Using the full 16-bit N:
  - N=0 -> DONE.
  - N > MEM_BYTES/4 -> ERR.
  - Otherwise -> DATA.
- DATA: on each transfer, shift the byte into the 32-bit assembly register and increment byte counter (0..3). On the 4th byte (counter=3), counter wraps to 0 and state goes to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1.
  - mem_addr = 4*loaded_words (ADDR_W bits); mem_wdata = assembled word.
  - On exit, loaded_words increments. If the incremented value equals N, go to DONE; else go to DATA.
- Write latency: mem_we is asserted in the cycle immediately after the edge that accepts a word's 4th byte.
- Minimum cost is 5 cycles per word at full throughput.
- in_ready is 1 in LEN_HI, LEN_LO and DATA; 0 in WRITE, DONE and ERR.
- in_valid gaps in DATA simply stall; partial-word state is retained.
- DONE: done=1 and cpu_hold=0. Stays here until reset; extra input bytes are never accepted.
- ERR: error=1 and cpu_hold=1. No memory writes. Stays here until reset.
- cpu_hold=1 in every state except DONE.
- mem_we, in_ready, done, error and cpu_hold are decoded from registered state only; there is no combinational path from in_valid or in_data.
- mem_addr and mem_wdata are meaningful only while mem_we=1; they hold their last values otherwise.
- Reset mid-operation:
  - Returns immediately to LEN_HI; any partial word is discarded with no write.
  - cpu_hold is reasserted.
  - Previously written memory contents are not cleared.
- Reset has priority over any simultaneous transfer.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> in_ready=1, cpu_hold=1, mem_we=0, done=0, error=0, loaded_words=0.
- Two-word load, continuous in_valid, bytes 00 02 20 08 00 05 AC 08 00 00 -> two writes:
  - addr 0, data 0x20080005, asserted on the cycle after byte 6 is accepted
  - addr 4, data 0xAC080000
  - then done=1, cpu_hold=0, loaded_words=2; an extra byte with in_valid=1 sees in_ready=0.
- Backpressure/gaps: same stream with in_valid toggled every other cycle -> identical writes and data. in_ready=0 during each WRITE cycle, and the byte presented then is accepted on the next cycle.
- Zero length: bytes 00 00 -> DONE two cycles after start, no mem_we pulses, cpu_hold=0.
- Overflow: bytes 00 81 (N=129, MEM_BYTES=512) -> error=1, in_ready=0, cpu_hold=1, no writes. Then reset=0 for 1 cycle -> error=0, in_ready=1.
- Reset mid-word: N=1, send 2 data bytes, then reset=0 -> no mem_we. Reload with 00 01 DE AD BE EF -> single write at addr 0 with 0xDEADBEEF, then done=1.
